// File: rtl/serial_add_pkg.sv
// Shared encodings and helpers for the bit-serial adder.
// Imported by the controller.
package serial_add_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fulladder_slice.sv
// Combinational full adder made of two half adders.
// Shared by every bit position of the serial adder.
module fulladder_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  halfadder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  halfadder u_ha1 (
    .a     (s0),
    .b     (cin),
    .sum   (sum),
    .carry (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/halfadder.sv
// Single-bit half adder.
// Building block of the full-adder slice.
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice, LSB first,
// valid/ready handshakes on operands and result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s;
  logic             c_nx;
  logic             last;

  fulladder_slice u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (s),
    .cout (c_nx)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB so the LSB-first stream lands in place.
  if (WIDTH == 1) begin : g_w1
    assign sum_sh = s;
  end else begin : g_wn
    assign sum_sh = {s, sum[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid)  state_nx = S_RUN;
      S_RUN:   if (last)      state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (in_ready && in_valid) begin
      sh_a  <= a;
      sh_b  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      sum   <= sum_sh;
      carry <= c_nx;
      cnt   <= cnt + CNT_W'(1);
      if (last) cout <= c_nx;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1),
// transaction-level model plus directed literal checks.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       v8 = 1'b0;
  logic       r8 = 1'b0;
  logic       cin8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       in_ready8;
  logic       out_valid8;
  logic       cout8;
  logic [7:0] sum8;

  logic       v1 = 1'b0;
  logic       r1 = 1'b0;
  logic       cin1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       in_ready1;
  logic       out_valid1;
  logic       cout1;
  logic [0:0] sum1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (r8),
    .sum       (sum8),
    .cout      (cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (r1),
    .sum       (sum1),
    .cout      (cout1)
  );

  // Transaction model: busy for WIDTH cycles, then holds a+b+cin until taken.
  bit         m8_busy = 1'b0;
  int         m8_left = 0;
  logic [8:0] m8_res = '0;
  bit         m1_busy = 1'b0;
  int         m1_left = 0;
  logic [1:0] m1_res = '0;

  always @(posedge clk) begin
    if (rst) m8_busy <= 1'b0;
    else if (!m8_busy) begin
      if (v8) begin
        m8_busy <= 1'b1;
        m8_left <= 8;
        m8_res  <= {1'b0, a8} + {1'b0, b8} + 9'(cin8);
      end
    end else if (m8_left > 0) m8_left <= m8_left - 1;
    else if (r8) m8_busy <= 1'b0;

    if (rst) m1_busy <= 1'b0;
    else if (!m1_busy) begin
      if (v1) begin
        m1_busy <= 1'b1;
        m1_left <= 1;
        m1_res  <= 2'(a1) + 2'(b1) + 2'(cin1);
      end
    end else if (m1_left > 0) m1_left <= m1_left - 1;
    else if (r1) m1_busy <= 1'b0;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready8", in_ready8, !m8_busy);
    chk("out_valid8", out_valid8, m8_busy && m8_left == 0);
    if (m8_busy && m8_left == 0)
      chk("result8", {cout8, sum8}, m8_res);
    chk("in_ready1", in_ready1, !m1_busy);
    chk("out_valid1", out_valid1, m1_busy && m1_left == 0);
    if (m1_busy && m1_left == 0)
      chk("result1", {cout1, sum1}, m1_res);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] es,
                     input logic ec, input int hold, input bit spam);
    int lat;
    v8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    tick();
    lat = 1;
    if (spam) begin
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    end else v8 = 1'b0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
    v8 = 1'b0;
    chk("lat8", lat, 9);
    chk("sum8", sum8, es);
    chk("cout8", cout8, ec);
    repeat (hold) begin
      tick();
      chk("hold_sum8", {cout8, sum8}, {ec, es});
    end
    r8 = 1'b1;
    tick();
    r8 = 1'b0;
    chk("ready_back8", in_ready8, 1);
    chk("valid_drop8", out_valid8, 0);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int lat;
    int tot;
    tot = int'(a) + int'(b) + int'(c);
    v1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    tick();
    v1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("lat1", lat, 2);
    chk("sum1", sum1, tot % 2);
    chk("cout1", cout1, tot / 2);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    chk("ready_back1", in_ready1, 1);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    rst = 1'b0;
    tick();

    op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
    op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 20, 1'b0);
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 1'b1);

    // Abort in the 4th RUN cycle.
    v8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
    tick();
    v8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready8, 1);
    chk("abort_out_valid", out_valid8, 0);
    chk("abort_sum", sum8, 0);
    op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] t;
      t = 3'(i);
      op1(t[2], t[1], t[0]);
    end

    repeat (600) begin
      v8   = 1'($urandom_range(0, 1));
      r8   = ($urandom_range(0, 3) != 0);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      v1   = 1'($urandom_range(0, 1));
      r1   = ($urandom_range(0, 2) != 0);
      a1   = 1'($urandom);
      b1   = 1'($urandom);
      cin1 = 1'($urandom);
      rst  = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0;
    v8 = 1'b0;
    v1 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
